// File: rtl/solver_ctrl.sv
// Batch sequencer for the four-stage solver bit pipeline.
// Accepts operand sets over valid/ready and drives the shared stage-register load enable.
// Tracks live pipeline slots, flags a valid result at the tail and stalls on backpressure.
// Runs a programmed batch length to completion, then pulses done.
module solver_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero = '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  logic             st_run;
  logic             st_active;
  logic             stall;
  logic             in_hs;
  logic             out_hs;
  logic             last_in;
  logic             last_out;
  logic [DEPTH:0]   vld_shift;

  // Handshake and pipeline-enable decode; in_valid reaches only next-state logic.
  always_comb begin
    st_run    = (state_q == StRun);
    st_active = (state_q == StRun) || (state_q == StDrain);
    out_valid = vld_q[DEPTH-1] & st_active;
    stall     = out_valid & ~out_ready;
    load      = st_active & ~stall;
    in_ready  = st_run & load & (issued_q < len_q);
    in_hs     = in_valid & in_ready;
    out_hs    = out_valid & out_ready;
    busy      = st_active;
    done      = (state_q == StDone);
    issued    = issued_q;
    retired   = retired_q;
    // The handshake that brings a counter up to the batch length.
    last_in   = in_hs && ((issued_q + CntOne) == len_q);
    last_out  = out_hs && ((retired_q + CntOne) == len_q);
    // New slot enters at bit 0; the tail slot falls off the top.
    vld_shift = {vld_q, in_hs};
  end

  // Next-state for FSM, batch length, counters and live-slot vector.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    vld_d     = vld_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d     = batch_len;
          issued_d  = CntZero;
          retired_d = CntZero;
          vld_d     = '0;
          state_d   = (batch_len == CntZero) ? StDone : StRun;
        end
      end

      StRun, StDrain: begin
        if (load) begin
          vld_d = vld_shift[DEPTH-1:0];
        end
        if (in_hs) begin
          issued_d = issued_q + CntOne;
        end
        if (out_hs) begin
          retired_d = retired_q + CntOne;
        end
        // Completion wins over the switch to draining.
        if (last_out) begin
          state_d = StDone;
        end else if (st_run && last_in) begin
          state_d = StDrain;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, cleared asynchronously together with the solver stages.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      vld_q     <= vld_d;
    end
  end

`ifndef SYNTHESIS
  // Counters never overrun the batch and never retire more than issued.
  a_issued_le_len : assert property (@(posedge clock) disable iff (!clear)
    issued_q <= len_q);
  a_retired_le_issued : assert property (@(posedge clock) disable iff (!clear)
    retired_q <= issued_q);
  // done is a single-cycle pulse.
  a_done_pulse : assert property (@(posedge clock) disable iff (!clear)
    done |=> !done);
  // Under backpressure the pipeline and the presented result hold.
  a_stall_hold : assert property (@(posedge clock) disable iff (!clear)
    stall |=> ($stable(vld_q) && out_valid));
  // The pipeline only advances while a batch is active.
  a_load_busy : assert property (@(posedge clock) disable iff (!clear)
    load |-> busy);
`endif

endmodule

// File: tb/tb_solver_ctrl.sv
// Directed bench for solver_ctrl with a behavioural stand-in for the solver stages.
// Cycle index 0 is the first cycle after the edge that samples start.
module tb_solver_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clock = 1'b0;
  logic             clear;
  logic             start;
  logic [CNT_W-1:0] batch_len;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             load;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] retired;

  always #5 clock = ~clock;

  solver_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .batch_len (batch_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .issued    (issued),
    .retired   (retired)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Solver stand-in: tags shift through DEPTH stages whenever load is high.
  logic [7:0] pipe [DEPTH];
  logic [7:0] tag_cnt;

  // Per-batch observations.
  int rel;
  int n_in, first_in, last_in;
  int n_ov, first_ov, last_ov;
  int n_done, done_at, busy_at_done, ret_at_done;
  int n_load, n_busy, first_busy;
  int tags [$];
  logic in_stall;
  int n_st, st_load, st_inr, st_ovlo, st_fchg;
  logic [7:0] st_f;

  task automatic reset_stats();
    rel = -1;
    n_in = 0; first_in = -100; last_in = -100;
    n_ov = 0; first_ov = -100; last_ov = -100;
    n_done = 0; done_at = -100; busy_at_done = -1; ret_at_done = -1;
    n_load = 0; n_busy = 0; first_busy = -100;
    tags.delete();
    n_st = 0; st_load = 0; st_inr = 0; st_ovlo = 0; st_fchg = 0; st_f = 8'd0;
    tag_cnt = 8'd0;
  endtask

  // One clock cycle: sample settled outputs mid-cycle, then advance past the edge.
  task automatic cycle();
    logic ld, ihs, ohs;
    #1;
    ld  = load;
    ihs = in_valid & in_ready;
    ohs = out_valid & out_ready;
    if (ihs) begin
      if (n_in == 0) first_in = rel;
      last_in = rel;
      n_in++;
    end
    if (out_valid) begin
      if (n_ov == 0) first_ov = rel;
      last_ov = rel;
      n_ov++;
    end
    if (ohs) tags.push_back(int'(pipe[DEPTH-1]));
    if (done) begin
      n_done++;
      done_at = rel;
      busy_at_done = int'(busy);
      ret_at_done = int'(retired);
    end
    if (load) n_load++;
    if (busy) begin
      if (n_busy == 0) first_busy = rel;
      n_busy++;
    end
    if (in_stall) begin
      if (n_st == 0) st_f = pipe[DEPTH-1];
      else if (pipe[DEPTH-1] != st_f) st_fchg++;
      if (load) st_load++;
      if (in_ready) st_inr++;
      if (!out_valid) st_ovlo++;
      n_st++;
    end
    @(posedge clock);
    if (ld) begin
      for (int i = DEPTH - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = tag_cnt;
    end
    if (ihs) tag_cnt++;
    rel++;
    #1;
  endtask

  task automatic check_tags(input string tag, input int n);
    check_eq({tag, "_count"}, tags.size(), n);
    for (int i = 0; i < n && i < tags.size(); i++) begin
      check_eq({tag, "_order"}, tags[i], i);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_load"}, 32'(load), 0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_issued"}, 32'(issued), 0);
    check_eq({tag, "_retired"}, 32'(retired), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int sc;
    clear = 1'b1; start = 1'b0; batch_len = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) pipe[i] = 8'd0;
    reset_stats();
    #2 clear = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;

    // Batch of 3 at full rate.
    reset_stats();
    batch_len = 8'd3; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (11) cycle();
    check_eq("b3_first_busy", first_busy, 0);
    check_eq("b3_n_in", n_in, 3);
    check_eq("b3_first_in", first_in, 0);
    check_eq("b3_last_in", last_in, 2);
    check_eq("b3_first_ov", first_ov, 4);
    check_eq("b3_last_ov", last_ov, 6);
    check_eq("b3_n_ov", n_ov, 3);
    check_eq("b3_n_done", n_done, 1);
    check_eq("b3_done_at", done_at, 7);
    check_eq("b3_busy_at_done", busy_at_done, 0);
    check_eq("b3_retired_at_done", ret_at_done, 3);
    check_tags("b3_tags", 3);
    check_eq("b3_idle_busy", 32'(busy), 0);

    // Batch of 4 with a 5-cycle output stall on the first result.
    reset_stats();
    batch_len = 8'd4; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    seen = 1'b0;
    sc = 0;
    for (int k = 0; k < 20; k++) begin
      if (!seen && out_valid) seen = 1'b1;
      if (seen && sc < 5) begin
        out_ready = 1'b0; in_stall = 1'b1; sc++;
      end else begin
        out_ready = 1'b1; in_stall = 1'b0;
      end
      cycle();
    end
    in_stall = 1'b0; out_ready = 1'b1;
    check_eq("st_n_in", n_in, 4);
    check_eq("st_first_ov", first_ov, 4);
    check_eq("st_stall_cycles", n_st, 5);
    check_eq("st_load_hi", st_load, 0);
    check_eq("st_in_ready_hi", st_inr, 0);
    check_eq("st_ov_dropped", st_ovlo, 0);
    check_eq("st_f_changed", st_fchg, 0);
    check_eq("st_f_value", 32'(st_f), 0);
    check_eq("st_n_ov", n_ov, 9);
    check_eq("st_done_at", done_at, 13);
    check_eq("st_n_done", n_done, 1);
    check_tags("st_tags", 4);

    // Batch of 2 with bubbles every other cycle.
    reset_stats();
    batch_len = 8'd2; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_valid = (k % 2 == 0);
      cycle();
    end
    check_eq("bb_n_in", n_in, 2);
    check_eq("bb_last_in", last_in, 2);
    check_eq("bb_first_ov", first_ov, 4);
    check_eq("bb_last_ov", last_ov, 6);
    check_eq("bb_n_ov", n_ov, 2);
    check_eq("bb_done_at", done_at, 7);
    check_eq("bb_n_done", n_done, 1);
    check_tags("bb_tags", 2);

    // Empty batch.
    reset_stats();
    batch_len = 8'd0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check_eq("z_n_done", n_done, 1);
    check_eq("z_done_at", done_at, 0);
    check_eq("z_n_load", n_load, 0);
    check_eq("z_n_busy", n_busy, 0);
    check_eq("z_n_in", n_in, 0);

    // start with a larger length mid-batch is ignored.
    reset_stats();
    batch_len = 8'd3; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    start = 1'b1; batch_len = 8'd9;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    check_eq("ig_n_in", n_in, 3);
    check_eq("ig_n_ov", n_ov, 3);
    check_eq("ig_done_at", done_at, 7);
    check_eq("ig_retired_at_done", ret_at_done, 3);
    check_eq("ig_n_done", n_done, 1);

    // Reset with two sets in flight.
    reset_stats();
    batch_len = 8'd4; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check_eq("cl_issued_before", 32'(issued), 2);
    clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) pipe[i] = 8'd0;
    #1;
    check_all_zero("cl_async");
    @(posedge clock); #1;
    clear = 1'b1;
    reset_stats();
    repeat (6) cycle();
    check_eq("cl_post_n_ov", n_ov, 0);
    check_eq("cl_post_n_load", n_load, 0);
    check_eq("cl_post_n_busy", n_busy, 0);
    reset_stats();
    batch_len = 8'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (8) cycle();
    check_eq("cl_new_first_ov", first_ov, 4);
    check_eq("cl_new_n_ov", n_ov, 1);
    check_eq("cl_new_done_at", done_at, 5);
    check_tags("cl_new_tags", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
